// File: rtl/show_state.sv
// Plays back a latched sequence of 2-bit colours on a one-hot LED bank.
// Each colour is lit for ON_CYCLES clocks, then the bank goes dark for OFF_CYCLES clocks.
module show_state #(
   parameter int unsigned ON_CYCLES  = 6000000,
   parameter int unsigned OFF_CYCLES = 2000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [31:0] sequence_val,
   input  logic [3:0]  sequence_len,
   output logic [3:0]  led,
   output logic [1:0]  colour_out,
   output logic        colour_valid,
   output logic        busy,
   output logic        complete_show
);

   typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

   localparam logic [23:0] OnLoad  = 24'(ON_CYCLES - 1);
   localparam logic [23:0] OffLoad = 24'(OFF_CYCLES - 1);

   state_e      state_q;
   logic [31:0] seq_q;
   logic [3:0]  len_q;
   logic [3:0]  idx_q;
   logic [23:0] cnt_q;
   logic [1:0]  cur_colour;

   assign cur_colour = seq_q[{idx_q, 1'b0} +: 2];

   // Outputs are registered from the current state, so they trail the state by one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         seq_q         <= '0;
         len_q         <= '0;
         idx_q         <= '0;
         cnt_q         <= '0;
         led           <= '0;
         colour_out    <= '0;
         colour_valid  <= 1'b0;
         busy          <= 1'b0;
         complete_show <= 1'b0;
      end else begin
         led           <= (state_q == StOn) ? (4'b0001 << cur_colour) : 4'b0000;
         colour_valid  <= (state_q == StOn);
         busy          <= (state_q == StOn) || (state_q == StOff);
         complete_show <= complete_show || (state_q == StDone);
         if (state_q == StOn) begin
            colour_out <= cur_colour;
         end

         case (state_q)
            StIdle: begin
               if (en) begin
                  seq_q   <= sequence_val;
                  len_q   <= sequence_len;
                  idx_q   <= '0;
                  cnt_q   <= OnLoad;
                  state_q <= (sequence_len == 4'd0) ? StDone : StOn;
               end
            end
            StOn: begin
               if (cnt_q == 24'd0) begin
                  cnt_q   <= OffLoad;
                  state_q <= StOff;
               end else begin
                  cnt_q <= cnt_q - 24'd1;
               end
            end
            StOff: begin
               if (cnt_q == 24'd0) begin
                  if (idx_q + 4'd1 == len_q) begin
                     state_q <= StDone;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     cnt_q   <= OnLoad;
                     state_q <= StOn;
                  end
               end else begin
                  cnt_q <= cnt_q - 24'd1;
               end
            end
            StDone: begin
               state_q <= StDone;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_show_state.sv
// Bench for show_state: timeline model of the playback plus directed literal checks
// and randomized runs with mid-run resets and input disturbance.
module tb_show_state;

   localparam int unsigned OnC  = 3;
   localparam int unsigned OffC = 2;
   localparam int          Per  = OnC + OffC;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [31:0] sequence_val = '0;
   logic [3:0]  sequence_len = '0;
   logic [3:0]  led;
   logic [1:0]  colour_out;
   logic        colour_valid;
   logic        busy;
   logic        complete_show;

   int checks = 0;
   int errors = 0;
   int e = 0;
   logic armed = 1'b0;

   show_state #(.ON_CYCLES(OnC), .OFF_CYCLES(OffC)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .sequence_val  (sequence_val),
      .sequence_len  (sequence_len),
      .led           (led),
      .colour_out    (colour_out),
      .colour_valid  (colour_valid),
      .busy          (busy),
      .complete_show (complete_show)
   );

   always #5 clk = ~clk;

   // Model: once started, edge t after the start maps to slot k=t-1 of a len*Per timeline.
   logic        running = 1'b0;
   int          t = 0;
   logic [31:0] m_seq = '0;
   int          m_len = 0;
   logic [3:0]  e_led = '0;
   logic [1:0]  e_col = '0;
   logic        e_cv = 1'b0;
   logic        e_busy = 1'b0;
   logic        e_cs = 1'b0;

   always @(posedge clk) begin
      int k, entry;
      logic [1:0] col;
      if (rst) begin
         running = 1'b0;
         e_led = '0; e_col = '0; e_cv = 1'b0; e_busy = 1'b0; e_cs = 1'b0;
      end else if (running) begin
         t = t + 1;
         k = t - 1;
         if (k >= m_len * Per) begin
            e_led = '0; e_cv = 1'b0; e_busy = 1'b0; e_cs = 1'b1;
         end else begin
            entry  = k / Per;
            col    = m_seq[2*entry +: 2];
            e_busy = 1'b1;
            e_cv   = (k % Per) < OnC;
            e_led  = e_cv ? (4'b0001 << col) : 4'b0000;
            if (e_cv) e_col = col;
         end
      end else if (en) begin
         running = 1'b1;
         t = 0;
         m_seq = sequence_val;
         m_len = int'(sequence_len);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, e, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("model_led", 32'(led), 32'(e_led));
         chk("model_colour_out", 32'(colour_out), 32'(e_col));
         chk("model_colour_valid", 32'(colour_valid), 32'(e_cv));
         chk("model_busy", 32'(busy), 32'(e_busy));
         chk("model_complete", 32'(complete_show), 32'(e_cs));
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives en so that it is sampled at E0; returns at the negedge after E0.
   task automatic start(input logic [31:0] s, input logic [3:0] l, input logic hold);
      sequence_val = s;
      sequence_len = l;
      en = 1'b1;
      @(negedge clk);
      e = 0;
      if (!hold) en = 1'b0;
   endtask

   task automatic upto(input int n);
      repeat (n - e) @(negedge clk);
      e = n;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      armed = 1'b1;
      chk("reset_led", 32'(led), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_complete", 32'(complete_show), 32'h0);

      // Four-colour run.
      start(32'h000000E4, 4'd4, 1'b0);
      upto(1);  chk("e4_led_e1", 32'(led), 32'h1);
      upto(3);  chk("e4_led_e3", 32'(led), 32'h1);
      upto(4);  chk("e4_led_e4", 32'(led), 32'h0);
      chk("e4_busy_e4", 32'(busy), 32'h1);
      upto(6);  chk("e4_led_e6", 32'(led), 32'h2);
      upto(11); chk("e4_led_e11", 32'(led), 32'h4);
      upto(16); chk("e4_led_e16", 32'(led), 32'h8);
      upto(19); chk("e4_col_off", 32'(colour_out), 32'h3);
      upto(20); chk("e4_done_e20", 32'(complete_show), 32'h0);
      upto(21); chk("e4_done_e21", 32'(complete_show), 32'h1);
      chk("e4_busy_e21", 32'(busy), 32'h0);
      do_reset();

      // Empty sequence.
      start(32'h000000E4, 4'd0, 1'b0);
      upto(1);  chk("len0_done", 32'(complete_show), 32'h1);
      upto(6);
      do_reset();

      // Reset mid-run, then a fresh single-entry run.
      start(32'h000000E4, 4'd4, 1'b0);
      upto(6);
      rst = 1'b1;
      upto(7);  chk("abort_led", 32'(led), 32'h0);
      chk("abort_col", 32'(colour_out), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      upto(8);
      start(32'h00000002, 4'd1, 1'b0);
      upto(1);  chk("restart_led", 32'(led), 32'h4);
      upto(5);  chk("restart_done_early", 32'(complete_show), 32'h0);
      upto(6);  chk("restart_done", 32'(complete_show), 32'h1);
      do_reset();

      // en held high, inputs disturbed after start.
      start(32'h000000E4, 4'd4, 1'b1);
      upto(2);
      sequence_val = 32'hFFFFFFFF;
      sequence_len = 4'd2;
      upto(6);  chk("hold_led_e6", 32'(led), 32'h2);
      upto(11); chk("hold_led_e11", 32'(led), 32'h4);
      upto(21); chk("hold_done", 32'(complete_show), 32'h1);
      upto(35); chk("hold_no_restart", 32'(busy), 32'h0);
      chk("hold_done_sticky", 32'(complete_show), 32'h1);
      en = 1'b0;
      do_reset();

      // Longest sequence; top entry never played.
      start(32'h3FFFFFFF, 4'd15, 1'b0);
      upto(71); chk("max_led", 32'(led), 32'h8);
      upto(75); chk("max_done_early", 32'(complete_show), 32'h0);
      upto(76); chk("max_done", 32'(complete_show), 32'h1);
      chk("max_col", 32'(colour_out), 32'h3);
      do_reset();

      // Randomized runs.
      for (int r = 0; r < 40; r++) begin
         int len, dur, abort_at;
         len = $urandom_range(0, 15);
         start($urandom, 4'(len), 1'($urandom_range(0, 1)));
         dur = len * Per + $urandom_range(2, 6);
         abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dur) : -1;
         for (int c = 1; c <= dur; c++) begin
            if ($urandom_range(0, 3) == 0) sequence_val = $urandom;
            if ($urandom_range(0, 3) == 0) sequence_len = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) en = 1'($urandom_range(0, 1));
            rst = (c == abort_at);
            upto(c);
         end
         rst = 1'b0;
         en = 1'b0;
         do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
